ft245_fifo_port: RTL and testbench
==================================

Name: ft245_fifo_port

Overview:
- Asynchronous FT245-style byte-interface engine between the board's USB FIFO pins (`fifo_d`, `fifo_rxf_n`, `fifo_txe_n`, `fifo_rd_n`, `fifo_wr_n`) and the FPGA's internal byte streams.
- Pulls host bytes out of the FIFO into a valid/ready RX stream.
- Pushes TX stream bytes into the FIFO.
- Replaces the bringup toggling of the FIFO pins and becomes the first stage of the host command path. The top level instantiates the tristate for `fifo_d`.

Parameters:
- RD_LOW_CYCLES, 2, cycles `fifo_rd_n` is held low per read (≥1); data is sampled at the end of the last low cycle.
- RECOVER_CYCLES, 3, idle cycles after every transfer before the flags are trusted again (≥1; covers the 2-flop synchroniser plus precharge).

Ports:
- `clk_12mhz` in 1: the single clock; all logic on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `fifo_rxf_n` in 1: FIFO has data when low; asynchronous, double-flop synchronised.
- `fifo_txe_n` in 1: FIFO can accept data when low; asynchronous, double-flop synchronised.
- `fifo_d_in` in 8: sampled pad value of `fifo_d`.
- `fifo_d_out` out 8: value driven onto `fifo_d`.
- `fifo_d_oe` out 1: drive enable for `fifo_d` (1 = FPGA drives).
- `fifo_rd_n` out 1: read strobe, active-low.
- `fifo_wr_n` out 1: write strobe, active-low.
- `rx_data` out 8: received byte.
- `rx_valid` out 1: `rx_data` holds an unconsumed byte.
- `rx_ready` in 1: consumer accepts the byte when `rx_valid` and `rx_ready` are both high.
- `tx_data` in 8: byte to send.
- `tx_valid` in 1: `tx_data` is offered.
- `tx_ready` out 1: a byte is taken when `tx_valid` and `tx_ready` are both high.
- `busy` out 1: FSM is not in IDLE.

Behaviour:
- Clock and reset: one clock `clk_12mhz`. `reset_n` is asynchronous and active-low.
- All outputs are registered, except `tx_ready` = !tx_full.
- Reset values: `fifo_rd_n`=1, `fifo_wr_n`=1, `fifo_d_oe`=0, `fifo_d_out`=0, `rx_data`=0, `rx_valid`=0, `tx_full`=0 (so `tx_ready`=1 once reset releases), `busy`=0, sync flops=1 (flags read as not-ready), last_served=TX.
- Reset mid-transfer forces the strobes high and `fifo_d_oe` low immediately (asynchronous). The partial byte is discarded.
- TX holding register:
  - One entry. The handshake loads `tx_data` and sets `tx_full`.
  - It is cleared on entry to WR_LOW.
  - Load and clear cannot coincide, because `tx_ready`=0 while full.
- RX output register:
  - `rx_valid` sets at the end of the final RD_LOW cycle and clears on the handshake.
  - A read is never started while `rx_valid`=1, so there is no overflow.
- FSM states: IDLE, RD_LOW, WR_SETUP, WR_LOW, WR_HOLD, RECOVER.
- IDLE:
  - rx_req = !rxf_sync & !`rx_valid`.
  - tx_req = !txe_sync & `tx_full`.
  - If both requests are present, serve the opposite of last_served (round-robin), then update last_served.
  - Otherwise serve whichever request is present, or stay in IDLE.
- RD_LOW:
  - `fifo_rd_n`=0 for exactly RD_LOW_CYCLES cycles; `fifo_d_oe`=0 throughout.
  - On the last cycle, capture `fifo_d_in` into `rx_data` and set `rx_valid`.
  - Then go to RECOVER; `fifo_rd_n` returns high on that same edge.
- WR_SETUP: 1 cycle; `fifo_d_oe`=1, `fifo_d_out`=held byte, `fifo_wr_n`=1.
- WR_LOW: 1 cycle; `fifo_wr_n`=0, data held.
- WR_HOLD: 1 cycle; `fifo_wr_n`=1, data and `fifo_d_oe` still held.
- RECOVER:
  - `fifo_d_oe`=0, both strobes high.
  - Counts RECOVER_CYCLES cycles, then returns to IDLE.
- Bus contention is forbidden: `fifo_d_oe` and `fifo_rd_n`=0 are never true in the same cycle. `fifo_rd_n` and `fifo_wr_n` are never both low.
- Latency:
  - Read: from IDLE with rx_req to `rx_valid` is RD_LOW_CYCLES cycles.
  - Write: from IDLE with tx_req to `fifo_wr_n` falling is 2 cycles.
  - Flag change to sync visibility is 2 cycles.
  - Back-to-back transfer period: reads RD_LOW_CYCLES+RECOVER_CYCLES+1 cycles; writes 3+RECOVER_CYCLES+1 cycles.
- Flags deasserting during a transfer do not abort it; the transfer completes. The flags are only sampled in IDLE.
- `busy` = (state != IDLE).

Test Plan:
- Reset check: hold `reset_n`=0 with `rxf_n`=0 and `txe_n`=0 → `rd_n`=`wr_n`=1, `d_oe`=0, `rx_valid`=0, `tx_ready`=1. Assert `reset_n` low during RD_LOW → `rd_n` goes high without waiting for a clock edge; after release no `rx_valid`.
- Single read: `rxf_n` falls with pad=0xA5 and `rx_ready`=0 → `rd_n` low for exactly 2 cycles starting 3 cycles after the flag edge; `rx_valid`=1 with `rx_data`=0xA5; no second read until the handshake.
- Single write: offer 0x3C with `txe_n`=0 → `d_oe`=1 for 3 cycles; `wr_n` low only in the middle cycle; `d_out`=0x3C throughout; `tx_ready` reasserts after WR_LOW.
- Contention/arbitration: `rxf_n`=0 and `txe_n`=0 held, `rx_ready`=1, stream of 4 TX bytes → transfers alternate R,W,R,W,...; ≥RECOVER_CYCLES+1 cycles with both strobes high between transfers; never `d_oe`=1 while `rd_n`=0.
- Flag flicker: `rxf_n` low for 1 cycle only → no read (synchroniser plus IDLE-only sampling). `txe_n` rises during WR_SETUP → the write completes, then waits.
- Throughput: 16 bytes with `rxf_n` held low and `rx_ready`=1 → 16 bytes in order; period = 2+3+1 = 6 cycles per byte.

Source files
------------

// File: rtl/ft245_fifo_port.sv
// FT245-style asynchronous FIFO port: pulls host bytes into a valid/ready RX
// stream and pushes a one-entry TX holding register out to the FIFO.
//
// state    | meaning
// IDLE     | flags sampled, round-robin between read and write requests
// RD_LOW   | fifo_rd_n low, byte captured on the last low cycle
// WR_SETUP | fifo_d driven with the held byte, strobe still high
// WR_LOW   | fifo_wr_n low, data held
// WR_HOLD  | fifo_wr_n back high, data still driven
// RECOVER  | bus released, waiting for the synchronised flags to settle
module ft245_fifo_port #(
  parameter int RD_LOW_CYCLES  = 2,
  parameter int RECOVER_CYCLES = 3
) (
  input  logic       clk_12mhz,
  input  logic       reset_n,
  input  logic       fifo_rxf_n,
  input  logic       fifo_txe_n,
  input  logic [7:0] fifo_d_in,
  output logic [7:0] fifo_d_out,
  output logic       fifo_d_oe,
  output logic       fifo_rd_n,
  output logic       fifo_wr_n,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RD_LOW   = 3'd1;
  localparam logic [2:0] S_WR_SETUP = 3'd2;
  localparam logic [2:0] S_WR_LOW   = 3'd3;
  localparam logic [2:0] S_WR_HOLD  = 3'd4;
  localparam logic [2:0] S_RECOVER  = 3'd5;

  localparam int CNT_MAX = (RD_LOW_CYCLES > RECOVER_CYCLES) ? RD_LOW_CYCLES : RECOVER_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] RD_LOAD  = CNT_W'(RD_LOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] REC_LOAD = CNT_W'(RECOVER_CYCLES - 1);

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             rxf_meta, rxf_sync;
  logic             txe_meta, txe_sync;
  logic [7:0]       tx_hold;
  logic             tx_full;
  logic             last_tx;
  logic             rx_req, tx_req;

  assign tx_ready = ~tx_full;
  assign rx_req   = ~rxf_sync & ~rx_valid;
  assign tx_req   = ~txe_sync & tx_full;

  always_ff @(posedge clk_12mhz or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      rxf_meta   <= 1'b1;
      rxf_sync   <= 1'b1;
      txe_meta   <= 1'b1;
      txe_sync   <= 1'b1;
      tx_hold    <= 8'h00;
      tx_full    <= 1'b0;
      last_tx    <= 1'b1;
      fifo_d_out <= 8'h00;
      fifo_d_oe  <= 1'b0;
      fifo_rd_n  <= 1'b1;
      fifo_wr_n  <= 1'b1;
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      rxf_meta <= fifo_rxf_n;
      rxf_sync <= rxf_meta;
      txe_meta <= fifo_txe_n;
      txe_sync <= txe_meta;

      if (tx_valid && tx_ready) begin
        tx_hold <= tx_data;
        tx_full <= 1'b1;
      end
      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      case (state)
        S_IDLE: begin
          // on a tie the read wins only if the write went last
          if (rx_req && (!tx_req || last_tx)) begin
            state     <= S_RD_LOW;
            fifo_rd_n <= 1'b0;
            cnt       <= RD_LOAD;
            last_tx   <= 1'b0;
            busy      <= 1'b1;
          end else if (tx_req) begin
            state      <= S_WR_SETUP;
            fifo_d_oe  <= 1'b1;
            fifo_d_out <= tx_hold;
            last_tx    <= 1'b1;
            busy       <= 1'b1;
          end
        end
        S_RD_LOW: begin
          if (cnt == '0) begin
            rx_data   <= fifo_d_in;
            rx_valid  <= 1'b1;
            fifo_rd_n <= 1'b1;
            cnt       <= REC_LOAD;
            state     <= S_RECOVER;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_WR_SETUP: begin
          fifo_wr_n <= 1'b0;
          tx_full   <= 1'b0;
          state     <= S_WR_LOW;
        end
        S_WR_LOW: begin
          fifo_wr_n <= 1'b1;
          state     <= S_WR_HOLD;
        end
        S_WR_HOLD: begin
          fifo_d_oe <= 1'b0;
          cnt       <= REC_LOAD;
          state     <= S_RECOVER;
        end
        S_RECOVER: begin
          if (cnt == '0) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          fifo_rd_n <= 1'b1;
          fifo_wr_n <= 1'b1;
          fifo_d_oe <= 1'b0;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ft245_fifo_port.sv
// Bench for ft245_fifo_port: cycle vector table for single read/write, directed
// reset/flicker sequences, and a queue-based FIFO/stream model for the rest.
module tb_ft245_fifo_port;

  localparam int RD_LOW  = 2;
  localparam int RECOVER = 3;

  logic       clk_12mhz = 1'b0;
  logic       reset_n;
  logic       fifo_rxf_n, fifo_txe_n;
  logic [7:0] fifo_d_in, fifo_d_out;
  logic       fifo_d_oe, fifo_rd_n, fifo_wr_n;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready, busy;

  ft245_fifo_port #(.RD_LOW_CYCLES(RD_LOW), .RECOVER_CYCLES(RECOVER)) dut (
    .clk_12mhz(clk_12mhz), .reset_n(reset_n),
    .fifo_rxf_n(fifo_rxf_n), .fifo_txe_n(fifo_txe_n),
    .fifo_d_in(fifo_d_in), .fifo_d_out(fifo_d_out), .fifo_d_oe(fifo_d_oe),
    .fifo_rd_n(fifo_rd_n), .fifo_wr_n(fifo_wr_n),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy)
  );

  always #5 clk_12mhz = ~clk_12mhz;

  typedef struct {
    logic [3:0] in_flags;   // {rxf_n, txe_n, rx_ready, tx_valid}
    logic [7:0] d_in;
    logic [7:0] tx_byte;
    logic [5:0] exp_flags;  // {rd_n, wr_n, d_oe, rx_valid, busy, tx_ready}
    logic [7:0] exp_dout;
    logic [7:0] exp_rxd;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;

  // observation trackers
  logic prev_rd, prev_oe;
  int   rd_run, idle_run, cyc;
  int   xfer_log[$];
  int   xfer_time[$];

  // reference model of the FIFO chip and both streams
  logic [7:0] host_q[$];
  logic [7:0] exp_rx_q[$];
  logic [7:0] exp_tx_q[$];
  bit   model_on, rx_rand, tx_rand, flag_rand;
  int   tx_left, rx_got, wr_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [3:0] f, input logic [7:0] d, input logic [7:0] t,
                              input logic [5:0] e, input logic [7:0] ed, input logic [7:0] er);
    vec_t v;
    v.in_flags = f; v.d_in = d; v.tx_byte = t;
    v.exp_flags = e; v.exp_dout = ed; v.exp_rxd = er;
    return v;
  endfunction

  task automatic trk_reset();
    prev_rd = 1'b1; prev_oe = 1'b0; rd_run = 0; idle_run = 100; cyc = 0;
    xfer_log.delete(); xfer_time.delete();
  endtask

  task automatic idle_inputs();
    fifo_rxf_n = 1'b1; fifo_txe_n = 1'b1; fifo_d_in = 8'h00;
    rx_ready = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
  endtask

  task automatic apply_reset();
    model_on = 1'b0;
    idle_inputs();
    reset_n = 1'b0;
    repeat (3) @(negedge clk_12mhz);
    reset_n = 1'b1;
    trk_reset();
  endtask

  task automatic model_init(input int n_host, input int n_tx);
    host_q.delete(); exp_rx_q.delete(); exp_tx_q.delete();
    for (int i = 0; i < n_host; i++) host_q.push_back(8'($urandom));
    tx_left = n_tx; rx_got = 0; wr_cnt = 0; model_on = 1'b1;
  endtask

  // advance one cycle and check the pin-level protocol at the falling edge
  task automatic step();
    bit start_r, start_w;
    @(negedge clk_12mhz);
    cyc++;
    check("contention", 32'({fifo_d_oe & ~fifo_rd_n, ~fifo_rd_n & ~fifo_wr_n}), 32'd0);
    if (!fifo_rd_n) rd_run++;
    if (fifo_rd_n && !prev_rd && rd_run > 0) begin
      check("rd_low_len", 32'(rd_run), 32'(RD_LOW));
      rd_run = 0;
      if (model_on) begin
        check("rd_host_nonempty", 32'(host_q.size() > 0), 32'd1);
        if (host_q.size() > 0) exp_rx_q.push_back(host_q.pop_front());
      end
    end
    start_r = !fifo_rd_n && prev_rd;
    start_w = fifo_d_oe && !prev_oe;
    if (start_r || start_w) begin
      check("gap", 32'(idle_run >= RECOVER + 1), 32'd1);
      idle_run = 0;
      xfer_log.push_back(int'(start_w));
      xfer_time.push_back(cyc);
    end
    if (fifo_rd_n && !fifo_d_oe) idle_run++;
    if (!fifo_wr_n && model_on) begin
      wr_cnt++;
      check("wr_expected", 32'(exp_tx_q.size() > 0), 32'd1);
      if (exp_tx_q.size() > 0) check("wr_data", 32'(fifo_d_out), 32'(exp_tx_q.pop_front()));
    end
    prev_rd = fifo_rd_n;
    prev_oe = fifo_d_oe;
  endtask

  // drive the FIFO chip and stream sides for the next cycle
  task automatic model_drive();
    rx_ready = rx_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (rx_valid && rx_ready) begin
      rx_got++;
      check("rx_expected", 32'(exp_rx_q.size() > 0), 32'd1);
      if (exp_rx_q.size() > 0) check("rx_data", 32'(rx_data), 32'(exp_rx_q.pop_front()));
    end
    tx_data  = 8'($urandom);
    tx_valid = (tx_left > 0) && (tx_rand ? ($urandom_range(0, 1) == 1) : 1'b1);
    if (tx_valid && tx_ready) begin
      exp_tx_q.push_back(tx_data);
      tx_left--;
    end
    if (host_q.size() == 0) begin
      fifo_rxf_n = 1'b1;
      fifo_d_in  = 8'($urandom);
    end else begin
      fifo_rxf_n = flag_rand ? 1'($urandom_range(0, 1)) : 1'b0;
      fifo_d_in  = host_q[0];
    end
    fifo_txe_n = flag_rand ? 1'($urandom_range(0, 1)) : 1'b0;
  endtask

  vec_t vecs[19];

  initial begin
    bit found;
    int nlog;

    vecs[0]  = mk(4'b0100, 8'hA5, 8'h00, 6'b110001, 8'h00, 8'h00);
    vecs[1]  = mk(4'b0100, 8'hA5, 8'h00, 6'b110001, 8'h00, 8'h00);
    vecs[2]  = mk(4'b0100, 8'hA5, 8'h00, 6'b010011, 8'h00, 8'h00);
    vecs[3]  = mk(4'b0100, 8'hA5, 8'h00, 6'b010011, 8'h00, 8'h00);
    vecs[4]  = mk(4'b0100, 8'hA5, 8'h00, 6'b110111, 8'h00, 8'hA5);
    vecs[5]  = mk(4'b0100, 8'hA5, 8'h00, 6'b110111, 8'h00, 8'hA5);
    vecs[6]  = mk(4'b0100, 8'hA5, 8'h00, 6'b110111, 8'h00, 8'hA5);
    vecs[7]  = mk(4'b1100, 8'hA5, 8'h00, 6'b110101, 8'h00, 8'hA5);
    vecs[8]  = mk(4'b1100, 8'hA5, 8'h00, 6'b110101, 8'h00, 8'hA5);
    vecs[9]  = mk(4'b1110, 8'hA5, 8'h00, 6'b110001, 8'h00, 8'h00);
    vecs[10] = mk(4'b1001, 8'h00, 8'h3C, 6'b110000, 8'h00, 8'h00);
    vecs[11] = mk(4'b1000, 8'h00, 8'h00, 6'b110000, 8'h00, 8'h00);
    vecs[12] = mk(4'b1000, 8'h00, 8'h00, 6'b111010, 8'h3C, 8'h00);
    vecs[13] = mk(4'b1000, 8'h00, 8'h00, 6'b101011, 8'h3C, 8'h00);
    vecs[14] = mk(4'b1100, 8'h00, 8'h00, 6'b111011, 8'h3C, 8'h00);
    vecs[15] = mk(4'b1100, 8'h00, 8'h00, 6'b110011, 8'h00, 8'h00);
    vecs[16] = mk(4'b1100, 8'h00, 8'h00, 6'b110011, 8'h00, 8'h00);
    vecs[17] = mk(4'b1100, 8'h00, 8'h00, 6'b110011, 8'h00, 8'h00);
    vecs[18] = mk(4'b1100, 8'h00, 8'h00, 6'b110001, 8'h00, 8'h00);
    model_on = 1'b0; rx_rand = 1'b0; tx_rand = 1'b0; flag_rand = 1'b0;
    trk_reset();

    // reset held with both flags asserted
    idle_inputs();
    reset_n = 1'b0;
    fifo_rxf_n = 1'b0; fifo_txe_n = 1'b0;
    repeat (4) @(negedge clk_12mhz);
    check("rst_ctl", 32'({fifo_rd_n, fifo_wr_n, fifo_d_oe, rx_valid, busy, tx_ready}), 32'b110001);
    check("rst_data", 32'({fifo_d_out, rx_data}), 32'd0);

    // reset asserted in the middle of RD_LOW
    fifo_txe_n = 1'b1;
    reset_n = 1'b1;
    trk_reset();
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      found = !fifo_rd_n;
    end
    check("rd_start_timeout", 32'(found), 32'd1);
    #2 reset_n = 1'b0;
    #1 check("async_rst_strobe", 32'({fifo_rd_n, fifo_d_oe}), 32'b10);
    trk_reset();
    fifo_rxf_n = 1'b1;
    @(negedge clk_12mhz);
    reset_n = 1'b1;
    repeat (6) step();
    check("after_rst_no_rx", 32'({rx_valid, busy}), 32'd0);

    // cycle table: single read of 0xA5, then single write of 0x3C
    apply_reset();
    foreach (vecs[i]) begin
      {fifo_rxf_n, fifo_txe_n, rx_ready, tx_valid} = vecs[i].in_flags;
      fifo_d_in = vecs[i].d_in;
      tx_data   = vecs[i].tx_byte;
      step();
      check($sformatf("vec%0d_ctl", i),
            32'({fifo_rd_n, fifo_wr_n, fifo_d_oe, rx_valid, busy, tx_ready}),
            32'(vecs[i].exp_flags));
      if (vecs[i].exp_flags[3]) check($sformatf("vec%0d_dout", i), 32'(fifo_d_out), 32'(vecs[i].exp_dout));
      if (vecs[i].exp_flags[2]) check($sformatf("vec%0d_rxd", i), 32'(rx_data), 32'(vecs[i].exp_rxd));
    end

    // sub-cycle glitch on rxf_n while idle
    nlog = xfer_log.size();
    #1 fifo_rxf_n = 1'b0;
    #3 fifo_rxf_n = 1'b1;
    repeat (8) step();
    check("glitch_no_read", 32'(xfer_log.size()), 32'(nlog));

    // txe_n rises and rxf_n pulses for one cycle while a write is under way
    fifo_txe_n = 1'b0; tx_valid = 1'b1; tx_data = 8'h5A;
    step();
    tx_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      found = fifo_d_oe;
    end
    check("wr_setup_timeout", 32'(found), 32'd1);
    fifo_txe_n = 1'b1; fifo_rxf_n = 1'b0; tx_valid = 1'b1; tx_data = 8'hC3;
    step();
    check("flicker_wr_low", 32'({fifo_wr_n, fifo_d_out}), 32'({1'b0, 8'h5A}));
    fifo_rxf_n = 1'b1;
    step();
    tx_valid = 1'b0;
    check("flicker_wr_hold", 32'({fifo_wr_n, fifo_d_oe}), 32'b11);
    nlog = xfer_log.size();
    repeat (12) step();
    check("flicker_waits", 32'({32'(xfer_log.size()) == 32'(nlog), tx_ready, rx_valid, busy}), 32'b1000);
    fifo_txe_n = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      found = !fifo_wr_n;
    end
    check("second_write", 32'({found, fifo_d_out}), 32'({1'b1, 8'hC3}));

    // arbitration: both flags held, 4 TX bytes, consumer always ready
    apply_reset();
    rx_rand = 1'b0; tx_rand = 1'b0; flag_rand = 1'b0;
    model_init(8, 4);
    for (int i = 0; i < 300 && xfer_log.size() < 12; i++) begin
      model_drive();
      step();
    end
    check("arb_count", 32'(xfer_log.size() >= 12), 32'd1);
    for (int i = 0; i < 12 && i < xfer_log.size(); i++)
      check($sformatf("arb_order%0d", i), 32'(xfer_log[i]), 32'((i < 8) ? (i % 2) : 0));

    // throughput: 16 reads back to back
    apply_reset();
    model_init(16, 0);
    for (int i = 0; i < 400 && rx_got < 16; i++) begin
      model_drive();
      step();
    end
    repeat (20) begin
      model_drive();
      step();
    end
    check("tput_bytes", 32'(rx_got), 32'd16);
    check("tput_reads", 32'(xfer_log.size()), 32'd16);
    for (int i = 1; i < xfer_log.size(); i++)
      check($sformatf("tput_period%0d", i), 32'(xfer_time[i] - xfer_time[i-1]), 32'(RD_LOW + RECOVER + 1));

    // randomized traffic against the queue model
    apply_reset();
    rx_rand = 1'b1; tx_rand = 1'b1; flag_rand = 1'b1;
    model_init(40, 40);
    found = 1'b0;
    for (int i = 0; i < 8000 && !found; i++) begin
      model_drive();
      step();
      found = (host_q.size() == 0) && (exp_rx_q.size() == 0) && (tx_left == 0) &&
              (exp_tx_q.size() == 0) && !busy;
    end
    check("rand_drain", 32'(found), 32'd1);
    check("rand_rx_count", 32'(rx_got), 32'd40);
    check("rand_wr_count", 32'(wr_cnt), 32'd40);

    model_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
